// File: rtl/ddr_sample_reader.sv
// Reads packed 3x10-bit ADC capture words from an MCB read port and streams them out as samples.
// Optional DDR_READER_SAMPLE_COUNT_EN adds a saturating accepted-sample counter (sample_count_o).
module ddr_sample_reader #(
   parameter int BURST_WORDS = 64,
   parameter int ADDR_W      = 30
) (
   input  logic              clk_100mhz_in,
   input  logic              reset_n_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [31:0]       num_words_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic              cmd_en_o,
   output logic [2:0]        cmd_instr_o,
   output logic [5:0]        cmd_bl_o,
   output logic [ADDR_W-1:0] cmd_byte_addr_o,
   input  logic              cmd_full_i,
   output logic              rd_en_o,
   input  logic [31:0]       rd_data_i,
   input  logic              rd_empty_i,
   input  logic              rd_overflow_i,
   input  logic              rd_error_i,
   output logic [9:0]        sample_o,
   output logic              sample_or_o,
   output logic              sample_trig_o,
   output logic              sample_valid_o,
`ifdef DDR_READER_SAMPLE_COUNT_EN
   output logic [31:0]       sample_count_o,
`endif
   input  logic              sample_ready_i
);

   localparam int BL_W = $clog2(BURST_WORDS + 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       words_left_q;
   logic [BL_W-1:0]   burst_left_q;
   logic [BL_W-1:0]   burst;
   logic              error_q;

   logic [31:0]       word_p1;
   logic              vld_p1;
   logic [1:0]        phase_p1;

   logic              start_acc;
   logic              cmd_fire;
   logic              accept;
   logic              last_accept;
   logic              pop;

   function automatic logic [9:0] unpack_sample(input logic [31:0] w, input logic [1:0] ph);
      case (ph)
         2'd0:    return w[9:0];
         2'd1:    return w[19:10];
         default: return w[29:20];
      endcase
   endfunction

   assign start_acc   = (state_q == IDLE) && start_i;
   assign cmd_fire    = (state_q == CMD) && !cmd_full_i;
   assign accept      = vld_p1 && sample_ready_i;
   assign last_accept = accept && (phase_p1 == 2'd2);
   // A new word may enter only when the buffer is empty or its last sample leaves this cycle.
   assign pop         = (state_q == DATA) && !rd_empty_i && (burst_left_q != '0) &&
                        (!vld_p1 || last_accept);

   always_comb begin
      burst = BL_W'(BURST_WORDS);
      if (words_left_q < 32'(BURST_WORDS))
         burst = BL_W'(words_left_q);
   end

   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_i) state_d = (num_words_i == '0) ? DONE : CMD;
         CMD:  if (!cmd_full_i) state_d = DATA;
         DATA: if ((burst_left_q == '0) && last_accept)
                  state_d = (words_left_q != '0) ? CMD : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o          = (state_q != IDLE);
      done_o          = (state_q == DONE);
      cmd_en_o        = cmd_fire;
      cmd_instr_o     = 3'b001;
      cmd_bl_o        = '0;
      if (state_q == CMD)
         cmd_bl_o = 6'(burst - BL_W'(1));
      cmd_byte_addr_o = addr_q;
      rd_en_o         = pop;
      error_o         = error_q;
   end

   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i) begin
         addr_q       <= '0;
         words_left_q <= '0;
         burst_left_q <= '0;
         error_q      <= 1'b0;
      end else begin
         error_q <= (error_q && !start_acc) || rd_overflow_i || rd_error_i;
         if (start_acc) begin
            addr_q       <= start_addr_i & ~ADDR_W'(3);
            words_left_q <= num_words_i;
         end else if (cmd_fire) begin
            addr_q       <= addr_q + ADDR_W'({burst, 2'b00});
            words_left_q <= words_left_q - 32'(burst);
            burst_left_q <= burst;
         end else if (pop) begin
            burst_left_q <= burst_left_q - BL_W'(1);
         end
      end
   end

   // ---- stage p1: one-word unpack buffer ----
   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i) begin
         vld_p1   <= 1'b0;
         phase_p1 <= 2'd0;
      end else if (pop) begin
         vld_p1   <= 1'b1;
         phase_p1 <= 2'd0;
      end else if (accept) begin
         if (phase_p1 == 2'd2)
            vld_p1 <= 1'b0;
         else
            phase_p1 <= phase_p1 + 2'd1;
      end
   end

   always_ff @(posedge clk_100mhz_in) begin
      if (pop)
         word_p1 <= rd_data_i;
   end

   // Outputs are masked by valid so the unreset word register never shows through.
   always_comb begin
      sample_valid_o = vld_p1;
      sample_o       = '0;
      sample_or_o    = 1'b0;
      sample_trig_o  = 1'b0;
      if (vld_p1) begin
         sample_o      = unpack_sample(word_p1, phase_p1);
         sample_or_o   = word_p1[31];
         sample_trig_o = word_p1[30];
      end
   end

`ifdef DDR_READER_SAMPLE_COUNT_EN
   logic [31:0] count_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i)
         count_q <= '0;
      else if (start_acc)
         count_q <= '0;
      else if (accept)
         count_q <= sat_inc(count_q);
   end

   assign sample_count_o = count_q;
`endif

endmodule

// File: tb/tb_ddr_sample_reader.sv
// Bench for ddr_sample_reader: MCB read-port model, job planner reference and stream scoreboard.
module tb_ddr_sample_reader;

   localparam int AW = 30;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic [AW-1:0] start_addr_i;
   logic [31:0]   num_words_i;
   logic          busy_o, done_o, error_o, cmd_en_o;
   logic [2:0]    cmd_instr_o;
   logic [5:0]    cmd_bl_o;
   logic [AW-1:0] cmd_byte_addr_o;
   logic          cmd_full_i;
   logic          rd_en_o;
   logic [31:0]   rd_data_i;
   logic          rd_empty_i, rd_overflow_i, rd_error_i;
   logic [9:0]    sample_o;
   logic          sample_or_o, sample_trig_o, sample_valid_o, sample_ready_i;
`ifdef DDR_READER_SAMPLE_COUNT_EN
   logic [31:0]   sample_count_o;
`endif

   always #5 clk = ~clk;

   ddr_sample_reader #(.BURST_WORDS(64), .ADDR_W(AW)) dut (
      .clk_100mhz_in(clk), .reset_n_i(rst_n), .start_i(start_i),
      .start_addr_i(start_addr_i), .num_words_i(num_words_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .cmd_en_o(cmd_en_o), .cmd_instr_o(cmd_instr_o), .cmd_bl_o(cmd_bl_o),
      .cmd_byte_addr_o(cmd_byte_addr_o), .cmd_full_i(cmd_full_i),
      .rd_en_o(rd_en_o), .rd_data_i(rd_data_i), .rd_empty_i(rd_empty_i),
      .rd_overflow_i(rd_overflow_i), .rd_error_i(rd_error_i),
      .sample_o(sample_o), .sample_or_o(sample_or_o), .sample_trig_o(sample_trig_o),
      .sample_valid_o(sample_valid_o),
`ifdef DDR_READER_SAMPLE_COUNT_EN
      .sample_count_o(sample_count_o),
`endif
      .sample_ready_i(sample_ready_i)
   );

   typedef struct packed {logic [9:0] s; logic o; logic t;} smp_t;
   typedef struct packed {logic [5:0] bl; logic [AW-1:0] a;} cmd_t;
   typedef struct {
      logic [AW-1:0] addr;
      int            nwords;
      int            rdy_mode;
      bit            rnd_empty;
      int            exp_cmds;
      int            exp_last_bl;
      logic [AW-1:0] exp_last_addr;
   } job_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;

   logic [31:0] fifo_q[$];
   smp_t        exp_smp[$];
   cmd_t        exp_cmd[$];
   smp_t        acc_log[$];
   int          outstanding = 0;
   bit          err_exp = 0;
   int          rdy_mode = 0;
   bit          rnd_empty = 0;
   bit          fixed_en = 0;
   logic [31:0] fixed_word = '0;
   bit          t_start = 0, t_full = 0, t_ovf = 0;
   logic [AW-1:0] t_addr = '0;
   logic [31:0] t_nwords = '0;
   bit          prev_stall = 0;
   smp_t        prev_smp;
   int          job_n = 0, done_cnt = 0, cmd_cnt = 0, samples_job = 0;
   int unsigned start_cyc = 0, last_acc_cyc = 0, first_acc_cyc = 0;
   logic [5:0]  last_bl;
   logic [AW-1:0] last_addr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [AW-1:0] ba);
      logic [31:0] i;
      if (fixed_en) return fixed_word;
      i = {4'd0, ba[AW-1:2]};
      return (i * 32'h9E3779B1) ^ {i[15:0], i[31:16]};
   endfunction

   // Reference: split the job into bursts and list the samples in delivery order.
   task automatic plan_job(input logic [AW-1:0] addr, input int n);
      logic [AW-1:0] a, base;
      logic [31:0]   w;
      int            rem, b;
      base = addr & ~AW'(3);
      a    = base;
      rem  = n;
      while (rem > 0) begin
         b = (rem > 64) ? 64 : rem;
         exp_cmd.push_back('{bl: 6'(b - 1), a: a});
         a   = a + AW'(4 * b);
         rem = rem - b;
      end
      for (int k = 0; k < n; k++) begin
         w = mem_word(base + AW'(4 * k));
         exp_smp.push_back('{s: w[9:0],   o: w[31], t: w[30]});
         exp_smp.push_back('{s: w[19:10], o: w[31], t: w[30]});
         exp_smp.push_back('{s: w[29:20], o: w[31], t: w[30]});
      end
   endtask

   task automatic start_job(input logic [AW-1:0] addr, input int n);
      plan_job(addr, n);
      job_n = n; done_cnt = 0; cmd_cnt = 0; samples_job = 0;
      acc_log.delete();
      t_addr = addr; t_nwords = 32'(n); t_start = 1;
   endtask

   // One clock: drive at the falling edge, observe mid-low-phase, update the model.
   task automatic cycle();
      smp_t        cur;
      bit          rdy, acc;
      logic [AW-1:0] a;
      @(negedge clk);
      start_i = t_start; start_addr_i = t_addr; num_words_i = t_nwords;
      cmd_full_i = t_full; rd_overflow_i = t_ovf; rd_error_i = 1'b0;
      t_start = 0; t_ovf = 0;
      case (rdy_mode)
         0:       rdy = 1'b1;
         1:       rdy = ($urandom_range(0, 3) != 0);
         default: rdy = ((cyc % 3) == 0);
      endcase
      sample_ready_i = rdy;
      rd_empty_i = (fifo_q.size() == 0) || (rnd_empty && $urandom_range(0, 3) == 0);
      rd_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
      #1;
      cur = '{s: sample_o, o: sample_or_o, t: sample_trig_o};
      acc = sample_valid_o && rdy;
      chk("error_flag", 64'(error_o), 64'(err_exp));
      chk("valid_vs_model", 64'(sample_valid_o), 64'(outstanding > 0));
      if (prev_stall) begin
         chk("stall_valid", 64'(sample_valid_o), 64'd1);
         chk("stall_hold", 64'(cur), 64'(prev_smp));
      end
      if (rd_en_o) begin
         chk("pop_nonempty", 64'(rd_empty_i), 64'd0);
         chk("pop_gate", 64'(outstanding - (acc ? 1 : 0)), 64'd0);
      end
      if (acc) begin
         acc_log.push_back(cur);
         if (samples_job == 0) first_acc_cyc = cyc;
         samples_job++;
         last_acc_cyc = cyc;
         if (exp_smp.size() == 0) chk("extra_sample", 64'(cur), 64'hFFFF);
         else chk("sample", 64'(cur), 64'(exp_smp.pop_front()));
      end
      if (cmd_en_o) begin
         cmd_cnt++;
         chk("cmd_while_full", 64'(cmd_full_i), 64'd0);
         chk("cmd_drained", 64'(outstanding + fifo_q.size()), 64'd0);
         chk("cmd_instr", 64'(cmd_instr_o), 64'd1);
         if (exp_cmd.size() == 0) chk("extra_cmd", 64'(cmd_byte_addr_o), 64'hFFFF_FFFF_FFFF);
         else begin
            chk("cmd_bl", 64'(cmd_bl_o), 64'(exp_cmd[0].bl));
            chk("cmd_addr", 64'(cmd_byte_addr_o), 64'(exp_cmd[0].a));
            void'(exp_cmd.pop_front());
         end
         last_bl = cmd_bl_o; last_addr = cmd_byte_addr_o;
      end
      if (done_o) begin
         done_cnt++;
         if (job_n == 0) chk("done_after_start", 64'(cyc - start_cyc), 64'd1);
         else chk("done_after_last", 64'(cyc - last_acc_cyc), 64'd1);
         chk("done_samples_left", 64'(exp_smp.size()), 64'd0);
         chk("done_cmds_left", 64'(exp_cmd.size()), 64'd0);
`ifdef DDR_READER_SAMPLE_COUNT_EN
         chk("sample_count", 64'(sample_count_o), 64'(3 * job_n));
`endif
      end
      // model state update for the coming rising edge
      if (start_i && !busy_o) begin start_cyc = cyc; err_exp = 0; end
      if (rd_overflow_i || rd_error_i) err_exp = 1;
      if (rd_en_o && !rd_empty_i) begin void'(fifo_q.pop_front()); outstanding += 3; end
      if (acc) outstanding--;
      if (cmd_en_o)
         for (int i = 0; i <= int'(cmd_bl_o); i++) begin
            a = cmd_byte_addr_o + AW'(4 * i);
            fifo_q.push_back(mem_word(a));
         end
      prev_stall = sample_valid_o && !rdy;
      prev_smp   = cur;
      cyc++;
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (done_cnt == 0 && i < budget) begin cycle(); i++; end
      if (done_cnt == 0) begin
         n_checks++; n_fail++;
         $display("FAIL job_timeout: got no done_o, expected one within %0d cycles", budget);
      end
      cycle();
      chk("busy_cleared", 64'(busy_o), 64'd0);
      chk("done_once", 64'(done_cnt), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_done"}, 64'(done_o), 64'd0);
      chk({tag, "_error"}, 64'(error_o), 64'd0);
      chk({tag, "_cmd_en"}, 64'(cmd_en_o), 64'd0);
      chk({tag, "_cmd_instr"}, 64'(cmd_instr_o), 64'd1);
      chk({tag, "_cmd_bl"}, 64'(cmd_bl_o), 64'd0);
      chk({tag, "_cmd_addr"}, 64'(cmd_byte_addr_o), 64'd0);
      chk({tag, "_rd_en"}, 64'(rd_en_o), 64'd0);
      chk({tag, "_sample"}, 64'({sample_o, sample_or_o, sample_trig_o}), 64'd0);
      chk({tag, "_valid"}, 64'(sample_valid_o), 64'd0);
   endtask

   task automatic reset_model();
      fifo_q.delete(); exp_smp.delete(); exp_cmd.delete();
      outstanding = 0; err_exp = 0; prev_stall = 0;
   endtask

   job_t tbl[6];

   initial begin
      tbl[0] = '{addr: 30'h100,      nwords: 64,  rdy_mode: 0, rnd_empty: 0, exp_cmds: 1, exp_last_bl: 63, exp_last_addr: 30'h100};
      tbl[1] = '{addr: 30'h0,        nwords: 130, rdy_mode: 0, rnd_empty: 0, exp_cmds: 3, exp_last_bl: 1,  exp_last_addr: 30'h200};
      tbl[2] = '{addr: 30'h3FFFFF00, nwords: 100, rdy_mode: 1, rnd_empty: 1, exp_cmds: 2, exp_last_bl: 35, exp_last_addr: 30'h0};
      tbl[3] = '{addr: 30'h37,       nwords: 5,   rdy_mode: 1, rnd_empty: 1, exp_cmds: 1, exp_last_bl: 4,  exp_last_addr: 30'h34};
      tbl[4] = '{addr: 30'h1000,     nwords: 200, rdy_mode: 1, rnd_empty: 1, exp_cmds: 4, exp_last_bl: 7,  exp_last_addr: 30'h1300};
      tbl[5] = '{addr: 30'h20,       nwords: 1,   rdy_mode: 2, rnd_empty: 0, exp_cmds: 1, exp_last_bl: 0,  exp_last_addr: 30'h20};

      rst_n = 1'b0; start_i = 0; start_addr_i = '0; num_words_i = '0; cmd_full_i = 0;
      rd_data_i = '0; rd_empty_i = 1; rd_overflow_i = 0; rd_error_i = 0; sample_ready_i = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int j = 0; j < 6; j++) begin
         rdy_mode = tbl[j].rdy_mode; rnd_empty = tbl[j].rnd_empty;
         start_job(tbl[j].addr, tbl[j].nwords);
         wait_done(tbl[j].nwords * 24 + 100);
         chk("job_cmds", 64'(cmd_cnt), 64'(tbl[j].exp_cmds));
         chk("job_last_bl", 64'(last_bl), 64'(tbl[j].exp_last_bl));
         chk("job_last_addr", 64'(last_addr), 64'(tbl[j].exp_last_addr));
         chk("job_samples", 64'(samples_job), 64'(3 * tbl[j].nwords));
         if (tbl[j].rdy_mode == 0 && !tbl[j].rnd_empty && tbl[j].nwords <= 64)
            chk("job_no_bubbles", 64'(last_acc_cyc - first_acc_cyc), 64'(3 * tbl[j].nwords - 1));
      end

      // Stalled consumer on a word with every field at an extreme.
      fixed_en = 1; fixed_word = 32'hC00FFC01; rdy_mode = 2; rnd_empty = 0;
      start_job(30'h40, 2);
      wait_done(200);
      chk("stall_count", 64'(acc_log.size()), 64'd6);
      if (acc_log.size() >= 3) begin
         chk("stall_s0", 64'(acc_log[0]), 64'({10'h001, 2'b11}));
         chk("stall_s1", 64'(acc_log[1]), 64'({10'h3FF, 2'b11}));
         chk("stall_s2", 64'(acc_log[2]), 64'({10'h000, 2'b11}));
      end
      fixed_en = 0;

      // Zero-word job, with a second start while still busy.
      rdy_mode = 0;
      start_job(30'h0, 0);
      cycle();
      t_start = 1; t_addr = 30'h800; t_nwords = 32'd5;
      cycle();
      repeat (5) cycle();
      chk("zero_done_once", 64'(done_cnt), 64'd1);
      chk("zero_no_cmd", 64'(cmd_cnt), 64'd0);
      chk("zero_no_samples", 64'(samples_job), 64'd0);
      chk("zero_idle", 64'(busy_o), 64'd0);

      // Command FIFO full for 10 cycles, an ignored start, and an overflow pulse.
      rdy_mode = 1; rnd_empty = 1; t_full = 1;
      start_job(30'h400, 3);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin t_start = 1; t_addr = 30'h9000; t_nwords = 32'd7; end
         cycle();
         chk("full_no_cmd", 64'(cmd_en_o), 64'd0);
      end
      t_full = 0;
      repeat (3) cycle();
      t_ovf = 1;
      wait_done(200);
      chk("full_one_cmd", 64'(cmd_cnt), 64'd1);
      chk("err_sticky", 64'(error_o), 64'd1);
      repeat (3) cycle();
      start_job(30'h500, 2);
      wait_done(200);
      chk("err_cleared", 64'(error_o), 64'd0);

      // Asynchronous reset in the middle of a data phase.
      rdy_mode = 0; rnd_empty = 0;
      start_job(30'h2000, 64);
      repeat (20) cycle();
      chk("mid_job_busy", 64'(busy_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      reset_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      start_job(30'h100, 10);
      wait_done(400);
      chk("post_reset_cmds", 64'(cmd_cnt), 64'd1);
      chk("post_reset_samples", 64'(samples_job), 64'd30);

      // Random jobs against the planner.
      rdy_mode = 1; rnd_empty = 1;
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(0, 150);
         start_job(AW'($urandom), n);
         wait_done(n * 24 + 100);
         chk("rand_samples", 64'(samples_job), 64'(3 * n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
